// File: rtl/dmem_responder_if.sv
// dmem_responder_if: datapath <-> data-memory request/response bundle; ByteM exists only with DMEM_BYTE_ACCESS_EN
interface dmem_responder_if;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemReadyM;
  logic        ErrM;
  logic        StallMem;
`ifdef DMEM_BYTE_ACCESS_EN
  logic        ByteM;
  modport master (output MemReqM, MemWriteM, AddrM, WriteDataM, ByteM,
                  input ReadDataM, MemReadyM, ErrM, StallMem);
  modport slave (input MemReqM, MemWriteM, AddrM, WriteDataM, ByteM,
                 output ReadDataM, MemReadyM, ErrM, StallMem);
`else
  modport master (output MemReqM, MemWriteM, AddrM, WriteDataM,
                  input ReadDataM, MemReadyM, ErrM, StallMem);
  modport slave (input MemReqM, MemWriteM, AddrM, WriteDataM,
                 output ReadDataM, MemReadyM, ErrM, StallMem);
`endif
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory responder (IDLE/WAIT/DONE); DMEM_BYTE_ACCESS_EN adds byte loads/stores
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_cnt;
  logic        r_write, r_byte;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [31:0] r_mem [DEPTH];
  logic        w_idle, w_in_byte, w_cur_byte, w_cur_write, w_err, w_cur_err;
  logic [31:0] w_cur_addr, w_word, w_old, w_load, w_store;
  logic [4:0]  w_sh, w_ssh;
  function automatic logic fault(input logic [31:0] a, input logic b);
    return {2'b0, a[31:2]} >= 32'(DEPTH) || (!b && a[1:0] != 2'b0);
  endfunction
`ifdef DMEM_BYTE_ACCESS_EN
  assign w_in_byte = bus.ByteM;
`else
  assign w_in_byte = 1'b0;
`endif
  // the access entering DONE comes straight from the bus when LATENCY=0
  assign w_idle      = r_state == IDLE;
  assign w_cur_addr  = w_idle ? bus.AddrM : r_addr;
  assign w_cur_byte  = w_idle ? w_in_byte : r_byte;
  assign w_cur_write = w_idle ? bus.MemWriteM : r_write;
  assign w_cur_err   = fault(w_cur_addr, w_cur_byte);
  assign w_err       = fault(r_addr, r_byte);
  assign w_word      = r_mem[w_cur_addr[AW+1:2]];
  assign w_sh        = {w_cur_addr[1:0], 3'b0};
  assign w_load      = w_cur_byte ? (w_word >> w_sh) & 32'hFF : w_word;
  assign w_old       = r_mem[r_addr[AW+1:2]];
  assign w_ssh       = {r_addr[1:0], 3'b0};
  assign w_store     = r_byte ? (w_old & ~(32'hFF << w_ssh)) | ({24'b0, r_wdata[7:0]} << w_ssh) : r_wdata;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = bus.MemReqM ? (LATENCY == 0 ? DONE : WAIT) : IDLE;
      WAIT:    w_next = !bus.MemReqM ? IDLE : (r_cnt == 3'd1 ? DONE : WAIT);
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_idle && bus.MemReqM) begin
        r_write <= bus.MemWriteM;
        r_addr  <= bus.AddrM;
        r_wdata <= bus.WriteDataM;
        r_byte  <= w_in_byte;
        r_cnt   <= 3'(LATENCY);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_next == DONE) r_rdata <= w_cur_err ? '0 : (w_cur_write ? r_rdata : w_load);
    end
  end
  always_ff @(posedge clk)
    if (!reset && r_state == DONE && r_write && !w_err) r_mem[r_addr[AW+1:2]] <= w_store;
  assign bus.MemReadyM = r_state == DONE;
  assign bus.ErrM      = r_state == DONE && w_err;
  assign bus.ReadDataM = r_rdata;
  assign bus.StallMem  = bus.MemReqM && r_state != DONE;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH, default 64, number of 32-bit words in the data array.
REQ-002 Parameter: LATENCY, default 2, range 0..7, wait cycles inserted between request accept and response.
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: MemReqM  input  1  memory-stage request valid from the pipelined datapath.
REQ-006 Port: MemWriteM  input  1  1 = store, 0 = load; qualified by MemReqM.
REQ-007 Port: AddrM  input  32  byte address (the datapath ALU result).
REQ-008 Port: WriteDataM  input  32  store data.
REQ-009 Port: ReadDataM  output  32  load data returned to the datapath.
REQ-010 Port: MemReadyM  output  1  one-cycle response strobe; access is complete.
REQ-011 Port: ErrM  output  1  access fault, valid only while MemReadyM=1.
REQ-012 Port: StallMem  output  1  hazard-unit stall request.
REQ-013 Port (DMEM_BYTE_ACCESS_EN only): ByteM  input  1  1 = byte access (LDRB/STRB).

Function
REQ-014 FSM states: IDLE, WAIT, DONE.
REQ-015 IDLE: if MemReqM=1, latch MemWriteM, AddrM, WriteDataM (and ByteM), load the counter with LATENCY, and go to WAIT if LATENCY>0, else to DONE.
REQ-016 WAIT: decrement the counter each cycle; go to DONE on the cycle the counter reaches 0.
REQ-017 DONE: MemReadyM=1 for exactly this cycle; unconditionally return to IDLE next cycle.
REQ-018 Latency: a request accepted in cycle T gives MemReadyM=1 in cycle T+1+LATENCY.
REQ-019 Throughput: at most one access per LATENCY+2 cycles; a new request is only sampled in IDLE.
REQ-020 StallMem = MemReqM & ~MemReadyM, combinational.
REQ-021 Requester holds MemReqM, MemWriteM, AddrM, WriteDataM stable until it sees MemReadyM; the block uses only the values latched at accept.
REQ-022 If MemReqM drops in WAIT, abort: return to IDLE next cycle, no MemReadyM, no array write.
REQ-023 Word index = latched AddrM[31:2]; little-endian byte order.
REQ-024 Store: array written only on the DONE cycle, only when ErrM=0.
REQ-025 Load: ReadDataM registered; updated on the DONE cycle and held until the next DONE.
REQ-026 Fault: ErrM=1 if the word index >= DEPTH, or a word access has AddrM[1:0] != 0.
REQ-027 On fault: no write; ReadDataM=0.
REQ-028 A store followed by a load to the same address returns the stored data; no forwarding is needed because the accesses are serialized.

Reset
REQ-029 reset=1 forces IDLE, counter=0, MemReadyM=0, ErrM=0, ReadDataM=0 on the next edge.
REQ-030 Reset overrides any in-flight access; an aborted store is not written.
REQ-031 Array contents are not cleared by reset.

Configuration
REQ-032 Macro DMEM_BYTE_ACCESS_EN, when defined, adds the ByteM port.
REQ-033 With DMEM_BYTE_ACCESS_EN, a byte load returns the byte selected by AddrM[1:0], zero-extended to 32 bits.
REQ-034 With DMEM_BYTE_ACCESS_EN, a byte store writes only WriteDataM[7:0] into the selected byte lane; the other lanes are unchanged.
REQ-035 With DMEM_BYTE_ACCESS_EN, byte accesses are never misaligned.
REQ-036 Without DMEM_BYTE_ACCESS_EN, there is no ByteM port, all accesses are word accesses, and REQ-026 applies to all of them.

Verification
REQ-037 LATENCY=2: store 0xDEADBEEF to 0x10, request at cycle 5 -> MemReadyM=1 at cycle 8, StallMem=1 in cycles 5-7, ErrM=0.
REQ-038 Load from 0x10 after REQ-037 -> ReadDataM=0xDEADBEEF on the MemReadyM cycle, held afterwards.
REQ-039 Word load from 0x12 -> ErrM=1 and ReadDataM=0; load from 0x100 with DEPTH=64 -> ErrM=1, array unchanged.
REQ-040 LATENCY=0: back-to-back store then load -> MemReadyM asserted at accept+1 for each access, two cycles apart.
REQ-041 Store 0x12345678 to 0x20, then reset asserted in WAIT -> no MemReadyM; a later load from 0x20 returns the prior contents.
REQ-042 With DMEM_BYTE_ACCESS_EN: 0x20 holds 0x11223344; STRB 0xAA to 0x21 -> word reads 0x1122AA44; LDRB from 0x23 -> 0x00000011.
